// File: rtl/reservation_station_pool.sv
// rtl/reservation_station_pool.sv - Tomasulo reservation station pool between dispatch and one FU (optional OLDEST_FIRST_EN age-ordered select)
module reservation_station_pool #(
  parameter int DEPTH     = 4,
  parameter int NUM_SRC   = 3,
  parameter int XLEN      = 32,
  parameter int TAG_W     = 4,
  parameter int PAYLOAD_W = 16,
  parameter int BASE_TAG  = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [PAYLOAD_W-1:0]       disp_payload,
  input  logic [NUM_SRC*TAG_W-1:0]   disp_tags,
  input  logic [NUM_SRC*XLEN-1:0]    disp_vals,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [XLEN-1:0]            cdb_data,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [TAG_W-1:0]           issue_tag,
  output logic [NUM_SRC*XLEN-1:0]    issue_vals,
  output logic [PAYLOAD_W-1:0]       issue_payload,
  output logic [$clog2(DEPTH):0]     free_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]                  busy_q, busy_d;
  logic [NUM_SRC-1:0][TAG_W-1:0]     tag_q [DEPTH];
  logic [NUM_SRC-1:0][TAG_W-1:0]     tag_d [DEPTH];
  logic [NUM_SRC-1:0][XLEN-1:0]      val_q [DEPTH];
  logic [NUM_SRC-1:0][XLEN-1:0]      val_d [DEPTH];
  logic [PAYLOAD_W-1:0]              payload_q [DEPTH];
  logic [PAYLOAD_W-1:0]              payload_d [DEPTH];

  logic [DEPTH-1:0]                  ready;
  logic [DEPTH-1:0]                  cand;
  logic [IW-1:0]                     sel_idx;
  logic                              sel_valid;
  logic [IW-1:0]                     alloc_idx;
  logic                              do_disp;
  logic                              do_issue;

`ifdef OLDEST_FIRST_EN
  // age_q[i][j] = 1 means entry j was allocated before entry i
  logic [DEPTH-1:0]                  age_q [DEPTH];
  logic [DEPTH-1:0]                  age_d [DEPTH];
`endif

  // An entry is ready once busy with every operand tag cleared (registered state only)
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy_q[i];
      for (int k = 0; k < NUM_SRC; k++) begin
        if (tag_q[i][k] != '0) ready[i] = 1'b0;
      end
    end
  end

  // Issue candidates: any ready entry, or only those with no older ready entry
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef OLDEST_FIRST_EN
      cand[i] = ready[i] && ((age_q[i] & ready) == '0);
`else
      cand[i] = ready[i];
`endif
    end
  end

  // Pick the lowest-index candidate for issue and the lowest-index free entry for dispatch
  always_comb begin
    sel_idx   = '0;
    sel_valid = 1'b0;
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
      end
      if (!busy_q[i]) alloc_idx = IW'(i);
    end
  end

  // Free-entry count and dispatch acceptance straight from registered busy bits
  always_comb begin
    free_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_count = free_count + CW'(!busy_q[i]);
    end
    disp_ready = ~&busy_q;
  end

  assign do_disp  = disp_valid && disp_ready;
  assign do_issue = sel_valid && issue_ready;

  // Issue outputs mux the selected entry and read zero when nothing is presented
  always_comb begin
    issue_valid   = sel_valid;
    issue_tag     = '0;
    issue_vals    = '0;
    issue_payload = '0;
    if (sel_valid) begin
      issue_tag     = TAG_W'(BASE_TAG) + TAG_W'(sel_idx);
      issue_payload = payload_q[sel_idx];
      for (int k = 0; k < NUM_SRC; k++) begin
        issue_vals[k*XLEN +: XLEN] = val_q[sel_idx][k];
      end
    end
  end

  // Next state: CDB wake-up, issue release, dispatch with CDB bypass, then flush override
  always_comb begin
    busy_d    = busy_q;
    tag_d     = tag_q;
    val_d     = val_q;
    payload_d = payload_q;
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (busy_q[i] && cdb_valid && (cdb_tag != '0) && (tag_q[i][k] == cdb_tag)) begin
          val_d[i][k] = cdb_data;
          tag_d[i][k] = '0;
        end
      end
    end
    if (do_issue) busy_d[sel_idx] = 1'b0;
    if (do_disp) begin
      busy_d[alloc_idx]    = 1'b1;
      payload_d[alloc_idx] = disp_payload;
      for (int k = 0; k < NUM_SRC; k++) begin
        if (disp_tags[k*TAG_W +: TAG_W] == '0) begin
          tag_d[alloc_idx][k] = '0;
          val_d[alloc_idx][k] = disp_vals[k*XLEN +: XLEN];
        end else if (cdb_valid && (cdb_tag == disp_tags[k*TAG_W +: TAG_W])) begin
          tag_d[alloc_idx][k] = '0;
          val_d[alloc_idx][k] = cdb_data;
        end else begin
          tag_d[alloc_idx][k] = disp_tags[k*TAG_W +: TAG_W];
          val_d[alloc_idx][k] = '0;
        end
      end
    end
    if (flush) busy_d = '0;
  end

`ifdef OLDEST_FIRST_EN
  // New entry records the current busy set as older; its column is cleared so it is younger than all
  always_comb begin
    age_d = age_q;
    if (do_disp) begin
      for (int r = 0; r < DEPTH; r++) age_d[r][alloc_idx] = 1'b0;
      age_d[alloc_idx] = busy_q;
    end
    if (flush) begin
      for (int r = 0; r < DEPTH; r++) age_d[r] = '0;
    end
  end

  // Age matrix register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < DEPTH; r++) age_q[r] <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`endif

  // Entry state registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]     <= '0;
        val_q[i]     <= '0;
        payload_q[i] <= '0;
      end
    end else begin
      busy_q    <= busy_d;
      tag_q     <= tag_d;
      val_q     <= val_d;
      payload_q <= payload_d;
    end
  end

endmodule
